// File: rtl/multimode_counter.sv
// multimode_counter: modulus up/down counter with wrap/saturate, load/clear and prescaler.
// Define COUNTER_COMPARE_EN to add the cmp_val input and registered match pulse.
module multimode_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
`ifdef COUNTER_COMPARE_EN
    input  logic [WIDTH-1:0] cmp_val,
    output logic             match,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sat
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE-1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d, step_val;
    logic             tc_q, tc_d, step, step_tc, at_top, at_bot;

    always_comb begin
        at_top   = count_q == MAX;
        at_bot   = count_q == '0;
        step     = en && pre_q == PRE_LAST;
        step_val = dir ? (at_bot ? (mode ? count_q : MAX) : count_q - ONE)
                       : (at_top ? (mode ? count_q : '0) : count_q + ONE);
        // saturate mode pulses tc on arrival at the boundary, wrap mode on the wrap itself
        step_tc  = dir ? (at_bot ? !mode : mode && count_q == ONE)
                       : (at_top ? !mode : mode && count_q == MAX - ONE);
        pre_d    = (clear || load || step) ? '0 : en ? pre_q + PRE_ONE : pre_q;
        count_d  = clear ? '0 : load ? (load_val > MAX ? MAX : load_val) : step ? step_val : count_q;
        tc_d     = !clear && !load && step && step_tc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign sat   = mode & (dir ? at_bot : at_top);

`ifdef COUNTER_COMPARE_EN
    logic match_q, match_d;

    // a held value (saturate or idle) never re-pulses match
    always_comb match_d = !clear && (load || (step && step_val != count_q)) && count_d == cmp_val;

    always_ff @(posedge clk) begin
        if (rst) match_q <= 1'b0;
        else     match_q <= match_d;
    end

    assign match = match_q;
`endif
endmodule

// File: doc/multimode_counter.md
Name: multimode_counter

Overview:
Parametrised successor to the team's basic free-running counter. It is a WIDTH-bit counter with a programmable modulus, up/down direction, wrap or saturate mode, synchronous load and clear, and an enable-gated prescaler. It sits behind the top-level wrapper and drives the dedicated outputs. It also gives other blocks a terminal-count pulse.

Parameters:
WIDTH, 8, counter width in bits (2..16)
MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL
PRESCALE, 1, enabled clock cycles per count step (1..256)

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset, synchronous, active-high
en  in  1  count enable; gates the prescaler
dir  in  1  direction: 0 = up, 1 = down
mode  in  1  boundary mode: 0 = wrap, 1 = saturate
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load
clear  in  1  synchronous clear to 0
count  out  WIDTH  current count, registered
tc  out  1  terminal-count pulse, registered, one cycle wide
sat  out  1  saturated flag, combinational from registered state

Behaviour:
- Reset (rst=1 at a clock edge): count=0, tc=0, prescaler=0 (match=0 if the optional feature is built). Reset overrides every other input.
- Priority at each edge: rst > clear > load > step.
- clear: count=0, prescaler=0, tc=0.
- load:
  - count = min(load_val, MAX_VAL), prescaler=0, tc=0.
  - load is honoured when en=0.
- Prescaler:
  - Internal counter pre, range 0..PRESCALE-1.
  - It advances only when en=1; with en=0 it is frozen, not reset.
  - A step fires at an edge where en=1 and pre==PRESCALE-1; pre then returns to 0.
  - With PRESCALE=1, a step fires on every enabled cycle.
- Step, up (dir=0):
  - If count<MAX_VAL: count+1.
  - If count==MAX_VAL, wrap mode: count=0, tc=1.
  - If count==MAX_VAL, saturate mode: count is held, no tc.
- Step, down (dir=1):
  - If count>0: count-1.
  - If count==0, wrap mode: count=MAX_VAL, tc=1.
  - If count==0, saturate mode: count is held, no tc.
- Saturate arrival: in saturate mode, tc=1 on the step that moves count onto the boundary (MAX_VAL going up, 0 going down).
- tc timing: tc is high in the same cycle that count shows the post-step value. It is 0 on every other cycle.
- sat = mode & (dir ? count==0 : count==MAX_VAL).
- Arithmetic is modulo MAX_VAL+1, never modulo 2**WIDTH. count never exceeds MAX_VAL.
- Changes to dir or mode mid-run take effect on the next step. The prescaler is unaffected.
- rst asserted mid-prescale or mid-step: all state is 0 at the next edge. Counting resumes with the first enabled cycle after rst falls.

Optional Feature:
Macro COUNTER_COMPARE_EN.
- Defined:
  - Adds input cmp_val [WIDTH] and registered output match [1].
  - match=1 for exactly one cycle when count is updated (by a step or a load) to a value equal to cmp_val.
  - A held value does not re-pulse match; this covers saturate and en=0.
  - clear and rst force match=0.
- Undefined: the cmp_val and match ports and all compare logic are absent. Behaviour is otherwise identical.

Test Plan:
1. WIDTH=8, MAX_VAL=255, PRESCALE=1; en=1, dir=0, mode=0 for 256 cycles after reset -> count runs 1..255 then 0; tc=1 only in the cycle count returns to 0.
2. MAX_VAL=9, mode=0, dir=1; load 2, then en=1 -> count 1, 0, 9 (tc=1 with 9), 8.
3. mode=1, dir=0, MAX_VAL=9; load 7, en=1 -> count 8, 9 (tc=1), then 9 held with tc=0 and sat=1. Switch dir=1 -> 8, sat=0.
4. PRESCALE=4, en=1 for 6 cycles, then en=0 for 5 cycles, then en=1 for 2 cycles -> count=1 after cycle 4. It stays 1 while frozen and becomes 2 after the 2 re-enabled cycles.
5. clear=1 and load=1 together with load_val=5 -> count=0. Then load_val=200 with MAX_VAL=199 -> count=199.
6. count=0x5A mid-run, rst=1 for one edge -> count=0, tc=0. With COUNTER_COMPARE_EN and cmp_val=3, counting up from 0 -> match=1 only in the cycle count=3.
